matrix_feeder: RTL and testbench



---
 rtl/matrix_feeder.sv | 168 ++++++++++++++++
 tb/tb_matrix_feeder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/matrix_feeder.sv
// Operand frame buffer and in-order streamer for the matrix-multiply controller.
// Optional MATRIX_FEEDER_ABORT_EN adds an abort input that drops the current frame.
module matrix_feeder #(
  parameter int DATA_W    = 16,
  parameter int NUM_WORDS = 12,
  parameter int LOAD_LEAD = 1,
  parameter int FRAME_GAP = 18
) (
  input  logic              clk,
  input  logic              reset,
`ifdef MATRIX_FEEDER_ABORT_EN
  input  logic              abort,
`endif
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              cf_load,
  output logic [DATA_W-1:0] din,
  output logic              din_valid,
  output logic [3:0]        din_idx,
  output logic              busy,
  output logic              frame_done
);

  if (NUM_WORDS > 16 || NUM_WORDS < 2) begin : g_bad_words
    $error("matrix_feeder: NUM_WORDS must be in 2..16");
  end

  typedef enum logic [2:0] {
    FILL, LOAD, LEAD, STREAM, GAP
  } state_t;

  localparam int TW = 16;

  state_t            state, state_nx;
  logic [4:0]        count, count_nx;
  logic [3:0]        idx, idx_nx, idx_inc;
  logic [TW-1:0]     tmr, tmr_nx;
  logic [DATA_W-1:0] mem [16];

  logic              cf_nx, valid_nx, done_nx;
  logic [DATA_W-1:0] din_nx;
  logic [3:0]        didx_nx;
  logic              wr_acc, abort_hit;

`ifdef MATRIX_FEEDER_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign wr_ready = (state == FILL);
  assign busy     = ~wr_ready;
  assign wr_acc   = wr_en & wr_ready;
  assign idx_inc  = idx + 4'd1;

  always_comb begin
    state_nx = state;
    count_nx = count;
    idx_nx   = idx;
    tmr_nx   = tmr;
    cf_nx    = 1'b0;
    valid_nx = 1'b0;
    done_nx  = 1'b0;
    din_nx   = '0;
    didx_nx  = '0;
    case (state)
      FILL: begin
        if (wr_acc) begin
          count_nx = count + 5'd1;
          if (count == 5'(NUM_WORDS - 1)) begin
            state_nx = LOAD;
            cf_nx    = 1'b1;
          end
        end
      end
      LOAD: begin
        idx_nx = '0;
        if (LOAD_LEAD == 1) begin
          state_nx = STREAM;
          valid_nx = 1'b1;
          din_nx   = mem[0];
        end else begin
          state_nx = LEAD;
          tmr_nx   = TW'(LOAD_LEAD - 2);
        end
      end
      LEAD: begin
        if (tmr == '0) begin
          state_nx = STREAM;
          valid_nx = 1'b1;
          din_nx   = mem[0];
        end else begin
          tmr_nx = tmr - TW'(1);
        end
      end
      STREAM: begin
        if (idx == 4'(NUM_WORDS - 1)) begin
          done_nx = 1'b1;
          if (FRAME_GAP == 0) begin
            state_nx = FILL;
            count_nx = '0;
          end else begin
            state_nx = GAP;
            tmr_nx   = TW'(FRAME_GAP - 1);
          end
        end else begin
          idx_nx   = idx_inc;
          valid_nx = 1'b1;
          din_nx   = mem[idx_inc];
          didx_nx  = idx_inc;
        end
      end
      GAP: begin
        if (tmr == '0) begin
          state_nx = FILL;
          count_nx = '0;
        end else begin
          tmr_nx = tmr - TW'(1);
        end
      end
      default: begin
        state_nx = FILL;
        count_nx = '0;
      end
    endcase
    // abort wins over everything, including a completing write
    if (abort_hit) begin
      state_nx = FILL;
      count_nx = '0;
      cf_nx    = 1'b0;
      valid_nx = 1'b0;
      done_nx  = 1'b0;
      din_nx   = '0;
      didx_nx  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      count      <= '0;
      idx        <= '0;
      tmr        <= '0;
      cf_load    <= 1'b0;
      din        <= '0;
      din_valid  <= 1'b0;
      din_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      idx        <= idx_nx;
      tmr        <= tmr_nx;
      cf_load    <= cf_nx;
      din        <= din_nx;
      din_valid  <= valid_nx;
      din_idx    <= didx_nx;
      frame_done <= done_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_acc && !abort_hit)
      mem[count[3:0]] <= wr_data;
  end

endmodule

// File: tb/tb_matrix_feeder.sv
// Bench for matrix_feeder: two configurations driven together and
// compared each cycle against a latency-based frame model.
module tb_matrix_feeder;

  localparam int N   = 12;
  localparam int BIG = 1000;

`ifdef MATRIX_FEEDER_ABORT_EN
  localparam bit HAS_ABORT = 1'b1;
`else
  localparam bit HAS_ABORT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic             abort = 1'b0;
  logic [15:0]      wr_data = '0;
  logic [1:0]       wr_ready, cf_load, din_valid, busy, frame_done;
  logic [1:0][15:0] din;
  logic [1:0][3:0]  din_idx;

  int checks = 0;
  int errors = 0;

  bit          fill [2];
  int          cnt [2];
  int          since [2];
  logic [15:0] words [2][16];
  int          lead [2] = '{1, 3};
  int          gap [2]  = '{18, 0};

  always #5 clk = ~clk;

  matrix_feeder #(
    .DATA_W(16), .NUM_WORDS(N), .LOAD_LEAD(1), .FRAME_GAP(18)
  ) u_dut0 (
    .clk(clk), .reset(reset),
`ifdef MATRIX_FEEDER_ABORT_EN
    .abort(abort),
`endif
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready[0]),
    .cf_load(cf_load[0]), .din(din[0]), .din_valid(din_valid[0]),
    .din_idx(din_idx[0]), .busy(busy[0]), .frame_done(frame_done[0])
  );

  matrix_feeder #(
    .DATA_W(16), .NUM_WORDS(N), .LOAD_LEAD(3), .FRAME_GAP(0)
  ) u_dut1 (
    .clk(clk), .reset(reset),
`ifdef MATRIX_FEEDER_ABORT_EN
    .abort(abort),
`endif
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready[1]),
    .cf_load(cf_load[1]), .din(din[1]), .din_valid(din_valid[1]),
    .din_idx(din_idx[1]), .busy(busy[1]), .frame_done(frame_done[1])
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // since = cycles elapsed since the edge that completed the frame
  task automatic model_edge(input int k, input logic r, input logic we,
                            input logic [15:0] wd, input logic ab);
    if (r || ab) begin
      fill[k]  = 1'b1;
      cnt[k]   = 0;
      since[k] = BIG;
    end else begin
      if (since[k] < BIG) since[k]++;
      if (fill[k]) begin
        if (we) begin
          words[k][cnt[k]] = wd;
          cnt[k]++;
          if (cnt[k] == N) begin
            fill[k]  = 1'b0;
            since[k] = 1;
          end
        end
      end else if (since[k] >= 1 + lead[k] + N + gap[k]) begin
        fill[k] = 1'b1;
        cnt[k]  = 0;
      end
    end
  endtask

  task automatic compare(input int k);
    int d, l, ix;
    bit v;
    d  = since[k];
    l  = lead[k];
    v  = (d >= 1 + l) && (d <= l + N);
    ix = v ? d - 1 - l : 0;
    check($sformatf("i%0d_ready", k), 32'(wr_ready[k]), 32'(fill[k]));
    check($sformatf("i%0d_busy", k), 32'(busy[k]), 32'(!fill[k]));
    check($sformatf("i%0d_cf_load", k), 32'(cf_load[k]), 32'(d == 1));
    check($sformatf("i%0d_valid", k), 32'(din_valid[k]), 32'(v));
    check($sformatf("i%0d_idx", k), 32'(din_idx[k]), 32'(ix));
    check($sformatf("i%0d_din", k), 32'(din[k]),
          v ? 32'(words[k][ix]) : 32'd0);
    check($sformatf("i%0d_done", k), 32'(frame_done[k]),
          32'(d == 1 + l + N));
  endtask

  task automatic step(input logic r, input logic we, input logic [15:0] wd,
                      input logic ab);
    reset   = r;
    wr_en   = we;
    wr_data = wd;
    abort   = ab;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, r, we, wd, ab && HAS_ABORT);
    #1;
    for (int k = 0; k < 2; k++) compare(k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic write_seq(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, base + 16'(i), 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      fill[k]  = 1'b1;
      cnt[k]   = 0;
      since[k] = BIG;
    end
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h5555, 1'b0);

    write_seq(N, 16'h0001);
    idle(40);

    write_seq(N - 1, 16'h1000);
    idle(20);
    step(1'b0, 1'b1, 16'hBEEF, 1'b0);
    idle(40);

    write_seq(N, 16'h0100);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 16'hFFFF, 1'b0);
    write_seq(N - 1, 16'h0200);
    idle(40);

    write_seq(N, 16'h0300);
    begin
      int i;
      for (i = 0; i < 100 && since[0] != 1 + lead[0] + 5; i++) idle(1);
      check("wait_idx5", 32'(since[0] == 1 + lead[0] + 5), 32'd1);
    end
    step(1'b1, 1'b0, 16'h0, 1'b0);
    idle(40);
    write_seq(N, 16'h0400);
    idle(40);

    write_seq(N - 1, 16'h0500);
    step(1'b0, 1'b1, 16'h050B, 1'b1);
    write_seq(N, 16'h0600);
    idle(40);

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
           16'($urandom), $urandom_range(0, 99) < 2);
    end
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
